// File: rtl/sdram_arbiter.sv
// Purpose: share one 16-bit SDRAM port between audio (32-bit reads), a SPART
//          stream buffer (16-bit writes) and the CPU (32-bit reads/writes).
// Latency: grant at edge t, first command from t+1; done pulses in the DONE cycle.
// Backpressure: waitrequest freezes the command bus; SPART input is a one-entry
//          pending register, and an overwritten word raises sticky spart_overflow.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   cpu_op/addr/wdata/rdata/done CPU request (held until cpu_done), read result
//   audio_rd/addr/rdata/done     audio 32-bit read request and result
//   spart_wr/data/overflow       SPART append pulse, data word, sticky overflow
//   busy                         current owner: 00 free, 01 cpu, 10 spart, 11 audio
//   address..waitrequest         Avalon-style SDRAM master port
module sdram_arbiter #(
    parameter int ADDR_W      = 25,
    parameter int SPART_BASE  = 0,
    parameter int SPART_DEPTH = 1048576
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    input  logic              audio_rd,
    input  logic [ADDR_W-1:0] audio_addr,
    output logic [31:0]       audio_rdata,
    output logic              audio_done,
    input  logic              spart_wr,
    input  logic [15:0]       spart_data,
    output logic              spart_overflow,
    output logic [1:0]        busy,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        byteenable_n,
    output logic              chipselect,
    output logic [15:0]       writedata,
    output logic              read_n,
    output logic              write_n,
    input  logic [15:0]       readdata,
    input  logic              readdatavalid,
    input  logic              waitrequest
);

    localparam int CNT_W = (SPART_DEPTH > 1) ? $clog2(SPART_DEPTH) : 1;

    localparam logic [1:0] OWN_FREE  = 2'b00;
    localparam logic [1:0] OWN_CPU   = 2'b01;
    localparam logic [1:0] OWN_SPART = 2'b10;
    localparam logic [1:0] OWN_AUDIO = 2'b11;

    typedef enum logic [2:0] {IDLE, LOW, HIGH, RDWAIT, DONE} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  hi_addr;
    logic [15:0]        hi_data;
    logic               is_rd;
    logic [31:0]        rbuf, rbuf_nxt;
    logic [1:0]         rcnt, rcnt_nxt;
    logic [CNT_W-1:0]   spart_cnt;
    logic               pend_vld;
    logic [15:0]        pend_dat;

    logic               acc;
    logic               rd_take;
    logic               cpu_rd, cpu_wr;
    logic               grant_audio, grant_spart, grant_cpu;
    logic               pend_take;
    logic [ADDR_W-1:0]  spart_addr;

    assign byteenable_n = 2'b00;
    assign chipselect   = 1'b1;

    // A beat is accepted on any edge where a command is on the bus and the
    // SDRAM is not stalling.
    assign acc     = (~read_n | ~write_n) & ~waitrequest;
    assign rd_take = readdatavalid & ((state == LOW) | (state == HIGH) | (state == RDWAIT));

    assign cpu_rd = (cpu_op == 2'b01);
    assign cpu_wr = (cpu_op == 2'b10);

    // Fixed priority: audio > spart pending > cpu, evaluated in IDLE only.
    assign grant_audio = (state == IDLE) & audio_rd;
    assign grant_spart = (state == IDLE) & ~audio_rd & pend_vld;
    assign grant_cpu   = (state == IDLE) & ~audio_rd & ~pend_vld & (cpu_rd | cpu_wr);
    assign pend_take   = grant_spart;

    assign spart_addr = ADDR_W'(SPART_BASE) + ADDR_W'(spart_cnt);

    assign cpu_done   = (state == DONE) & (busy == OWN_CPU);
    assign audio_done = (state == DONE) & (busy == OWN_AUDIO);

    // Read-return collection: first word to [15:0], second to [31:16].
    always_comb begin
        rbuf_nxt = rbuf;
        rcnt_nxt = rcnt;
        if (state == IDLE) begin
            rcnt_nxt = 2'd0;
        end else if (rd_take && rcnt != 2'd2) begin
            if (rcnt == 2'd0) begin
                rbuf_nxt[15:0] = readdata;
            end else begin
                rbuf_nxt[31:16] = readdata;
            end
            rcnt_nxt = rcnt + 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_audio | grant_spart | grant_cpu) state_nxt = LOW;
            LOW:     if (acc) state_nxt = (busy == OWN_SPART) ? DONE : HIGH;
            HIGH:    if (acc) state_nxt = is_rd ? RDWAIT : DONE;
            RDWAIT:  if (rcnt_nxt == 2'd2) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= OWN_FREE;
            address     <= '0;
            writedata   <= '0;
            read_n      <= 1'b1;
            write_n     <= 1'b1;
            hi_addr     <= '0;
            hi_data     <= '0;
            is_rd       <= 1'b0;
            rbuf        <= '0;
            rcnt        <= '0;
            cpu_rdata   <= '0;
            audio_rdata <= '0;
            spart_cnt   <= '0;
        end else begin
            rbuf <= rbuf_nxt;
            rcnt <= rcnt_nxt;
            case (state)
                IDLE: begin
                    if (grant_audio) begin
                        busy    <= OWN_AUDIO;
                        address <= audio_addr;
                        hi_addr <= audio_addr + ADDR_W'(1);
                        read_n  <= 1'b0;
                        is_rd   <= 1'b1;
                    end else if (grant_spart) begin
                        busy      <= OWN_SPART;
                        address   <= spart_addr;
                        writedata <= pend_dat;
                        write_n   <= 1'b0;
                        is_rd     <= 1'b0;
                    end else if (grant_cpu) begin
                        busy      <= OWN_CPU;
                        address   <= cpu_addr;
                        hi_addr   <= cpu_addr + ADDR_W'(1);
                        writedata <= cpu_wdata[15:0];
                        hi_data   <= cpu_wdata[31:16];
                        read_n    <= ~cpu_rd;
                        write_n   <= ~cpu_wr;
                        is_rd     <= cpu_rd;
                    end
                end
                LOW: begin
                    if (acc) begin
                        if (busy == OWN_SPART) begin
                            write_n   <= 1'b1;
                            spart_cnt <= (spart_cnt == CNT_W'(SPART_DEPTH - 1)) ?
                                         '0 : spart_cnt + CNT_W'(1);
                        end else begin
                            address   <= hi_addr;
                            writedata <= hi_data;
                        end
                    end
                end
                HIGH: begin
                    if (acc) begin
                        read_n  <= 1'b1;
                        write_n <= 1'b1;
                    end
                end
                RDWAIT: begin
                    if (state_nxt == DONE) begin
                        if (busy == OWN_AUDIO) begin
                            audio_rdata <= rbuf_nxt;
                        end else begin
                            cpu_rdata <= rbuf_nxt;
                        end
                    end
                end
                DONE: begin
                    busy <= OWN_FREE;
                end
                default: begin
                    busy <= OWN_FREE;
                end
            endcase
        end
    end

    // One-entry SPART holding register; capture runs in every state. Overflow
    // only when a valid word is overwritten without being granted that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld       <= 1'b0;
            pend_dat       <= '0;
            spart_overflow <= 1'b0;
        end else begin
            if (spart_wr) begin
                pend_vld <= 1'b1;
                pend_dat <= spart_data;
                if (pend_vld && !pend_take) begin
                    spart_overflow <= 1'b1;
                end
            end else if (pend_take) begin
                pend_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    cpu_op = 2'b00;
    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [31:0]   cpu_rdata;
    logic          cpu_done;
    logic          audio_rd = 1'b0;
    logic [AW-1:0] audio_addr = '0;
    logic [31:0]   audio_rdata;
    logic          audio_done;
    logic          spart_wr = 1'b0;
    logic [15:0]   spart_data = '0;
    logic          spart_overflow;
    logic [1:0]    busy;
    logic [AW-1:0] address;
    logic [1:0]    byteenable_n;
    logic          chipselect;
    logic [15:0]   writedata;
    logic          read_n, write_n;
    logic [15:0]   readdata = '0;
    logic          readdatavalid = 1'b0;
    logic          waitrequest = 1'b0;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_W(AW), .SPART_BASE(0), .SPART_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .audio_rd(audio_rd), .audio_addr(audio_addr),
        .audio_rdata(audio_rdata), .audio_done(audio_done),
        .spart_wr(spart_wr), .spart_data(spart_data), .spart_overflow(spart_overflow),
        .busy(busy), .address(address), .byteenable_n(byteenable_n),
        .chipselect(chipselect), .writedata(writedata),
        .read_n(read_n), .write_n(write_n),
        .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- SDRAM model and monitors ----------------
    int              cyc = 0;
    int              rd_lat = 1;
    logic [AW+15:0]  wr_log[$];
    logic [AW-1:0]   rd_log[$];
    int              resp_due[$];
    logic [15:0]     rd_words[$];
    logic [1:0]      busy_log[$];
    logic [1:0]      last_busy = 2'b00;
    int              cpu_done_cnt = 0;
    int              audio_done_cnt = 0;
    logic            busy_bad = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst_n && !waitrequest) begin
            if (!write_n) wr_log.push_back({address, writedata});
            if (!read_n) begin
                rd_log.push_back(address);
                resp_due.push_back(cyc + rd_lat - 1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            resp_due.delete();
            rd_words.delete();
            readdatavalid = 1'b0;
        end else if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
            readdatavalid = 1'b1;
            readdata = (rd_words.size() > 0) ? rd_words.pop_front() : 16'hDEAD;
            void'(resp_due.pop_front());
        end else begin
            readdatavalid = 1'b0;
        end
        if (cpu_done === 1'b1) cpu_done_cnt++;
        if (audio_done === 1'b1) audio_done_cnt++;
        if (busy !== last_busy) begin
            if (busy !== 2'b00) busy_log.push_back(busy);
            last_busy = busy;
        end
    end

    function automatic logic [AW+15:0] wr_at(input int i);
        return (i < wr_log.size()) ? wr_log[i] : '1;
    endfunction

    function automatic logic [AW-1:0] rd_at(input int i);
        return (i < rd_log.size()) ? rd_log[i] : '1;
    endfunction

    task automatic wait_cpu_done(input string tag, input logic [1:0] own);
        int n = 0;
        while (cpu_done !== 1'b1 && n < 200) begin
            if (busy !== 2'b00 && busy !== own) busy_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        if (cpu_done !== 1'b1) check({tag, "_timeout"}, 64'd0, 64'd1);
        cpu_op = 2'b00;
    endtask

    task automatic spart_pulse(input logic [15:0] d);
        @(negedge clk);
        spart_wr = 1'b1;
        spart_data = d;
        @(negedge clk);
        spart_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- Directed stimulus ----------------
    initial begin
        int d0;
        int n;
        int exp_a[6];
        exp_a = '{0, 1, 2, 3, 0, 1};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 2'b00);
        check("rst_cmd", {read_n, write_n}, 2'b11);
        check("rst_addr", address, 0);
        check("rst_done", {cpu_done, audio_done, spart_overflow}, 3'b000);
        check("static_pins", {byteenable_n, chipselect}, 3'b001);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // V1: CPU 32-bit write
        wr_log.delete();
        d0 = cpu_done_cnt;
        busy_bad = 1'b0;
        cpu_op = 2'b10; cpu_addr = 25'h100; cpu_wdata = 32'hBEEF1234;
        wait_cpu_done("v1", 2'b01);
        check("v1_busy_at_done", busy, 2'b01);
        @(negedge clk);
        check("v1_busy_free", busy, 2'b00);
        check("v1_busy_const", busy_bad, 1'b0);
        check("v1_nwr", wr_log.size(), 2);
        check("v1_beat_lo", wr_at(0), {25'h100, 16'h1234});
        check("v1_beat_hi", wr_at(1), {25'h101, 16'hBEEF});
        check("v1_done_pulses", cpu_done_cnt - d0, 1);

        // V2: CPU read at top of address space, high half wraps to 0
        rd_log.delete();
        rd_lat = 1;
        rd_words.push_back(16'hAAAA);
        rd_words.push_back(16'h5555);
        @(negedge clk);
        cpu_op = 2'b01; cpu_addr = 25'h1FFFFFF;
        wait_cpu_done("v2", 2'b01);
        check("v2_rdata", cpu_rdata, 32'h5555AAAA);
        check("v2_addr_lo", rd_at(0), 25'h1FFFFFF);
        check("v2_addr_hi", rd_at(1), 25'h0000000);
        @(negedge clk);

        // V5a: six spaced SPART writes, depth 4
        wr_log.delete();
        for (int k = 0; k < 6; k++) begin
            spart_pulse(16'hC000 + 16'(k));
            repeat (20) @(negedge clk);
        end
        check("v5_nwr", wr_log.size(), 6);
        for (int k = 0; k < 6; k++)
            check("v5_spart_wr", wr_at(k), {25'(exp_a[k]), 16'hC000 + 16'(k)});
        check("v5_no_ovf", spart_overflow, 1'b0);

        // V5b: two back-to-back SPART pulses during a CPU write
        wr_log.delete();
        @(negedge clk);
        cpu_op = 2'b10; cpu_addr = 25'h400; cpu_wdata = 32'hCAFED00D;
        @(negedge clk);
        spart_wr = 1'b1; spart_data = 16'hAAA1;
        @(negedge clk);
        spart_data = 16'hAAA2;
        @(negedge clk);
        spart_wr = 1'b0;
        wait_cpu_done("v5b", 2'b01);
        repeat (10) @(negedge clk);
        check("v5b_ovf", spart_overflow, 1'b1);
        check("v5b_nwr", wr_log.size(), 3);
        check("v5b_cpu_lo", wr_at(0), {25'h400, 16'hD00D});
        check("v5b_cpu_hi", wr_at(1), {25'h401, 16'hCAFE});
        check("v5b_spart", wr_at(2), {25'h2, 16'hAAA2});

        // V3: audio, spart and cpu arrive together
        wr_log.delete();
        busy_log.delete();
        rd_lat = 1;
        rd_words.push_back(16'h1111);
        rd_words.push_back(16'h2222);
        @(negedge clk);
        audio_rd = 1'b1; audio_addr = 25'h200;
        spart_wr = 1'b1; spart_data = 16'h7777;
        cpu_op = 2'b10; cpu_addr = 25'h300; cpu_wdata = 32'h9ABCDEF0;
        @(negedge clk);
        spart_wr = 1'b0;
        n = 0;
        while (cpu_done !== 1'b1 && n < 200) begin
            if (audio_done === 1'b1) audio_rd = 1'b0;
            @(negedge clk);
            n++;
        end
        if (cpu_done !== 1'b1) check("v3_timeout", 64'd0, 64'd1);
        cpu_op = 2'b00;
        @(negedge clk);
        check("v3_nowners", busy_log.size(), 3);
        check("v3_order", {busy_log[0], busy_log[1], busy_log[2]}, 6'b11_10_01);
        check("v3_audio_rdata", audio_rdata, 32'h22221111);
        check("v3_spart", wr_at(0), {25'h3, 16'h7777});
        check("v3_cpu_hi", wr_at(2), {25'h301, 16'h9ABC});

        // V4: waitrequest held for 5 cycles on the LOW beat
        wr_log.delete();
        @(negedge clk);
        waitrequest = 1'b1;
        cpu_op = 2'b10; cpu_addr = 25'h500; cpu_wdata = 32'h87654321;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("v4_hold", {write_n, read_n, address, writedata},
                  {1'b0, 1'b1, 25'h500, 16'h4321});
        end
        check("v4_no_early", wr_log.size(), 0);
        waitrequest = 1'b0;
        wait_cpu_done("v4", 2'b01);
        @(negedge clk);
        check("v4_nwr", wr_log.size(), 2);
        check("v4_beat_hi", wr_at(1), {25'h501, 16'h8765});

        // V6: reset mid-RDWAIT; SPART count must also restart at 0
        wr_log.delete();
        spart_pulse(16'h0E01);
        repeat (8) @(negedge clk);
        check("v6_pre_spart", wr_at(0), {25'h0, 16'h0E01});
        d0 = cpu_done_cnt;
        rd_lat = 10;
        rd_words.push_back(16'h0BAD);
        rd_words.push_back(16'h0BAD);
        cpu_op = 2'b01; cpu_addr = 25'h600;
        repeat (4) @(negedge clk);
        check("v6_in_rdwait", {busy, read_n, write_n}, {2'b01, 1'b1, 1'b1});
        rst_n = 1'b0;
        #1;
        check("v6_rst_busy", busy, 2'b00);
        check("v6_rst_bus", {read_n, write_n, address, writedata}, {1'b1, 1'b1, 25'h0, 16'h0});
        check("v6_rst_rdata", {cpu_rdata, audio_rdata}, 64'h0);
        check("v6_rst_flags", {cpu_done, audio_done, spart_overflow}, 3'b000);
        cpu_op = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("v6_no_done", cpu_done_cnt - d0, 0);
        wr_log.delete();
        spart_pulse(16'h0E02);
        repeat (8) @(negedge clk);
        check("v6_spart_cnt0", wr_at(0), {25'h0, 16'h0E02});
        rd_log.delete();
        rd_lat = 2;
        rd_words.push_back(16'h1357);
        rd_words.push_back(16'h2468);
        cpu_op = 2'b01; cpu_addr = 25'h700;
        wait_cpu_done("v6_after", 2'b01);
        check("v6_after_rdata", cpu_rdata, 32'h24681357);
        check("v6_after_addr", {rd_at(0), rd_at(1)}, {25'h700, 25'h701});
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
